// File: rtl/sa_pkg.sv
// Shared types for the systolic-array drain path: drain FSM encoding and
// the column-index width helper.
package sa_pkg;

  typedef enum logic [1:0] {DR_IDLE, DR_SHIFT, DR_FLUSH} drain_state_t;

  // Column index width; a single-column array still gets a 1-bit index.
  function automatic int col_w(input int x);
    return (x > 1) ? $clog2(x) : 1;
  endfunction

endpackage

// File: rtl/sa_drain_fifo.sv
// Small synchronous skid FIFO. The head entry is read straight out of the
// storage registers, so the output never has a combinational input path.
module sa_drain_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;
  assign o_full  = (count == CW'(DEPTH));
  assign o_empty = (count == '0);
  assign o_head  = mem[rd_ptr];

  // Power-of-2 depth lets the pointers wrap naturally.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= i_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sa_cscan_drain.sv
// Drains the systolic array's C scan chain: X shifts per drain, one Y-wide
// column captured per shift, streamed out through a skid FIFO.
// Stream handshake: a beat transfers on every clock edge where o_valid and
// i_ready are both high; o_valid never depends on i_ready, and
// o_data/o_col/o_last hold steady while o_valid is high and i_ready is low.
module sa_cscan_drain
  import sa_pkg::*;
#(
  parameter int  X          = 3,
  parameter int  Y          = 3,
  parameter int  OC_W       = 48,
  parameter int  FIFO_DEPTH = 4,
  localparam int COL_W      = col_w(X)
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_start,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_overrun,
  output logic                     o_cscan_en,
  output logic [0:Y-1][OC_W-1:0]   o_c_chain,
  input  logic [0:Y-1][OC_W-1:0]   i_c_chain,
  output logic [0:Y-1][OC_W-1:0]   o_data,
  output logic [COL_W-1:0]         o_col,
  output logic                     o_last,
  output logic                     o_valid,
  input  logic                     i_ready,
  output drain_state_t             o_dbg_state
);

  localparam int               FW       = Y*OC_W + COL_W + 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(X-1);

  drain_state_t     state;
  drain_state_t     state_nx;
  logic [COL_W-1:0] cnt;
  logic             overrun;
  logic             fifo_full;
  logic             fifo_empty;
  logic             cap;
  logic             last_cap;
  logic             pop;
  logic             start_ok;
  logic [FW-1:0]    head;

  // Capture is gated only by registered state, so a pop never frees a slot
  // for a push in the same cycle.
  assign cap      = (state == DR_SHIFT) && !fifo_full;
  assign last_cap = cap && (cnt == LAST_COL);
  assign pop      = !fifo_empty && i_ready;
  assign start_ok = i_start && ((state == DR_IDLE) || o_done);

  always_comb begin
    state_nx = state;
    o_done   = 1'b0;
    case (state)
      DR_IDLE:  if (i_start) state_nx = DR_SHIFT;
      DR_SHIFT: if (last_cap) state_nx = DR_FLUSH;
      DR_FLUSH: begin
        // The last-flagged beat is always the final FIFO entry of a drain.
        if (pop && head[0]) begin
          o_done   = 1'b1;
          state_nx = i_start ? DR_SHIFT : DR_IDLE;
        end else if (fifo_empty) begin
          state_nx = DR_IDLE;
        end
      end
      default:  state_nx = DR_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state   <= DR_IDLE;
      cnt     <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_nx;
      if (cap) cnt <= last_cap ? '0 : cnt + 1'b1;
      if (i_start && !start_ok) overrun <= 1'b1;
    end
  end

  sa_drain_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_push  (cap),
    .i_data  ({i_c_chain, cnt, (cnt == LAST_COL)}),
    .i_pop   (pop),
    .o_head  (head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  // Zero-fill behind the drain leaves the chain cleared for the next context.
  assign o_c_chain                = '0;
  assign o_cscan_en               = cap;
  assign o_busy                   = (state != DR_IDLE);
  assign o_overrun                = overrun;
  assign o_valid                  = !fifo_empty;
  assign {o_data, o_col, o_last}  = head;
  assign o_dbg_state              = state;

endmodule

// File: tb/tb_sa_cscan_drain.sv
// Directed bench for sa_cscan_drain with an array C-chain model and an
// expected-beat queue.
module tb_sa_cscan_drain;
  import sa_pkg::*;

  localparam int X     = 3;
  localparam int Y     = 3;
  localparam int OC_W  = 48;
  localparam int FD    = 2;
  localparam int COL_W = 2;
  localparam int W     = Y*OC_W + COL_W + 1;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic ready = 1'b0;
  logic busy, done, overrun, cscan_en, valid, last;
  logic [0:Y-1][OC_W-1:0] c_out, c_in, data;
  logic [COL_W-1:0]       col;
  drain_state_t           dbg_state;

  logic [0:Y-1][OC_W-1:0] chain [X];
  logic [0:Y-1][OC_W-1:0] e;
  logic [W-1:0]           exp_q[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int beat_cnt = 0;
  int en_cnt = 0;
  int b0, d0;

  // clock / reset block
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  assign c_in = chain[0];

  sa_cscan_drain #(.X(X), .Y(Y), .OC_W(OC_W), .FIFO_DEPTH(FD)) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_start     (start),
    .o_busy      (busy),
    .o_done      (done),
    .o_overrun   (overrun),
    .o_cscan_en  (cscan_en),
    .o_c_chain   (c_out),
    .i_c_chain   (c_in),
    .o_data      (data),
    .o_col       (col),
    .o_last      (last),
    .o_valid     (valid),
    .i_ready     (ready),
    .o_dbg_state (dbg_state)
  );

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp();
    for (int c = 0; c < X; c++)
      exp_q.push_back({chain[c], COL_W'(c), (c == X-1)});
  endtask

  task automatic load_dir(input int b);
    for (int c = 0; c < X; c++)
      for (int r = 0; r < Y; r++)
        chain[c][r] = OC_W'(b*(c+1) + r);
    push_exp();
  endtask

  task automatic load_rand();
    for (int c = 0; c < X; c++)
      for (int r = 0; r < Y; r++)
        chain[c][r] = OC_W'({$urandom(), $urandom()});
    push_exp();
  endtask

  // One clock: sample/score at negedge, then advance the array chain model.
  task automatic step();
    logic en_s;
    logic [0:Y-1][OC_W-1:0] fill;
    @(negedge clk);
    chk("c_chain_zero", c_out, '0);
    en_s = cscan_en;
    fill = c_out;
    if (cscan_en) en_cnt++;
    if (done) done_cnt++;
    if (valid && ready) begin
      beat_cnt++;
      chk("beat_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("beat", {data, col, last}, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    if (en_s) begin
      for (int c = 0; c < X-1; c++) chain[c] = chain[c+1];
      chain[X-1] = fill;
    end
  endtask

  task automatic run_to_done(input string tag, input int max_steps, input bit rand_ready);
    int dd;
    int n;
    dd = done_cnt;
    n = 0;
    while (done_cnt == dd && n < max_steps) begin
      if (rand_ready) ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    chk({tag, "_done_seen"}, done_cnt - dd, 1);
  endtask

  initial begin
    for (int c = 0; c < X; c++) chain[c] = '0;

    // reset state
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_cscan", cscan_en, 0);
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_col", col, 0);
    chk("rst_last", last, 0);
    chk("rst_state", dbg_state, DR_IDLE);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    step();

    // basic drain, i_ready high throughout
    ready = 1'b1;
    load_dir(10);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_busy", busy, 1);
    chk("t1_cscan", cscan_en, 1);
    chk("t1_valid_c1", valid, 0);
    step();
    e = {48'd10, 48'd11, 48'd12};
    chk("t1_valid_c2", valid, 1);
    chk("t1_col0", col, 0);
    chk("t1_last0", last, 0);
    chk("t1_data0", data, e);
    chk("t1_done_early", done, 0);
    step();
    e = {48'd20, 48'd21, 48'd22};
    chk("t1_col1", col, 1);
    chk("t1_data1", data, e);
    chk("t1_last1", last, 0);
    step();
    chk("t1_col2", col, 2);
    chk("t1_last2", last, 1);
    chk("t1_done", done, 1);
    chk("t1_busy_flush", busy, 1);
    // start on the done cycle is accepted without overrun
    load_dir(40);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1b_busy", busy, 1);
    chk("t1b_cscan", cscan_en, 1);
    chk("t1b_overrun", overrun, 0);
    run_to_done("t1b", 20, 1'b0);
    chk("t1_beats", beat_cnt, 6);
    chk("t1_queue_empty", exp_q.size(), 0);
    step();
    chk("t1_idle", busy, 0);

    // FIFO full stalls the shift
    load_dir(50);
    ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    en_cnt = 0;
    b0 = beat_cnt;
    repeat (6) step();
    chk("t2_cscan_pulses", en_cnt, 2);
    chk("t2_valid", valid, 1);
    chk("t2_head_col", col, 0);
    ready = 1'b1;
    chk("t2_no_same_cycle_push", cscan_en, 0);
    run_to_done("t2", 20, 1'b0);
    chk("t2_cscan_total", en_cnt, 3);
    chk("t2_beats", beat_cnt - b0, 3);
    chk("t2_queue_empty", exp_q.size(), 0);

    // backpressure on beat 1
    load_dir(20);
    b0 = beat_cnt;
    ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    ready = 1'b0;
    e = {48'd40, 48'd41, 48'd42};
    repeat (4) begin
      step();
      chk("t3_hold_valid", valid, 1);
      chk("t3_hold_col", col, 1);
      chk("t3_hold_data", data, e);
    end
    ready = 1'b1;
    run_to_done("t3", 20, 1'b0);
    chk("t3_beats", beat_cnt - b0, 3);
    chk("t3_queue_empty", exp_q.size(), 0);

    // start while busy sets sticky overrun
    load_dir(30);
    b0 = beat_cnt;
    d0 = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("t4_overrun_pre", overrun, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t4_overrun", overrun, 1);
    chk("t4_busy", busy, 1);
    run_to_done("t4", 20, 1'b0);
    chk("t4_beats", beat_cnt - b0, 3);
    chk("t4_queue_empty", exp_q.size(), 0);
    step();
    step();
    chk("t4_overrun_sticky", overrun, 1);
    chk("t4_idle", busy, 0);
    chk("t4_single_done", done_cnt - d0, 1);

    // reset mid-drain after one capture
    load_dir(7);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("t5_busy_pre", busy, 1);
    rstn = 1'b0;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_valid", valid, 0);
    chk("t5_rst_cscan", cscan_en, 0);
    chk("t5_rst_overrun", overrun, 0);
    chk("t5_rst_data", data, 0);
    chk("t5_rst_col", col, 0);
    chk("t5_rst_last", last, 0);
    chk("t5_rst_done", done, 0);
    exp_q.delete();
    d0 = done_cnt;
    step();
    step();
    chk("t5_no_done", done_cnt - d0, 0);
    rstn = 1'b1;
    load_dir(9);
    b0 = beat_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    run_to_done("t5", 20, 1'b0);
    chk("t5_beats", beat_cnt - b0, 3);
    chk("t5_queue_empty", exp_q.size(), 0);

    // random backpressure over 100 drains
    b0 = beat_cnt;
    for (int d = 0; d < 100; d++) begin
      load_rand();
      ready = 1'($urandom_range(0, 1));
      start = 1'b1;
      step();
      start = 1'b0;
      run_to_done("rnd", 200, 1'b1);
    end
    chk("rnd_beats", beat_cnt - b0, 300);
    chk("rnd_queue_empty", exp_q.size(), 0);
    chk("rnd_overrun", overrun, 0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
